// File: rtl/rotor_stack.sv
// Sequential Enigma rotor stack: stepping with double-step, then one rotor per
// cycle forward, reflector, and one rotor per cycle backward.
module rotor_stack #(
   parameter int NUM_ROTORS = 3,
   parameter int IW = ($clog2(NUM_ROTORS) < 1) ? 1 : $clog2(NUM_ROTORS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cfg_we,
   input  logic [IW-1:0]           cfg_idx,
   input  logic [1:0]              cfg_wiring,
   input  logic [4:0]              cfg_ring,
   input  logic [4:0]              cfg_pos,
   input  logic                    in_valid,
   input  logic [4:0]              in_letter,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic [4:0]              out_letter,
   output logic [5*NUM_ROTORS-1:0] positions
);

   typedef enum logic [2:0] {IDLE, STEP, FWD, REFL, BWD, DONE} state_t;

   localparam logic [IW-1:0] LAST = IW'(NUM_ROTORS - 1);

   localparam logic [4:0] WIRE_I [26] = '{
      5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
   localparam logic [4:0] WIRE_II [26] = '{
      5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
   localparam logic [4:0] WIRE_III [26] = '{
      5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
   localparam logic [4:0] REFL_B [26] = '{
      5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
      5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

   function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] t;
      t = {1'b0, a} + {1'b0, b};
      if (t >= 6'd26) t = t - 6'd26;
      return t[4:0];
   endfunction

   function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] t;
      t = {1'b0, a} - {1'b0, b};
      if (a < b) t = t + 6'd26;
      return t[4:0];
   endfunction

   function automatic logic [4:0] wire_fwd(input logic [1:0] w, input logic [4:0] x);
      case (w)
         2'd0:    return WIRE_I[x];
         2'd1:    return WIRE_II[x];
         2'd2:    return WIRE_III[x];
         default: return x;
      endcase
   endfunction

   // Inverse found by searching the forward table instead of a second ROM.
   function automatic logic [4:0] wire_inv(input logic [1:0] w, input logic [4:0] y);
      logic [4:0] r;
      r = y;
      for (int unsigned i = 0; i < 26; i++)
         if (wire_fwd(w, 5'(i)) == y) r = 5'(i);
      return r;
   endfunction

   function automatic logic at_notch(input logic [1:0] w, input logic [4:0] p);
      case (w)
         2'd0:    return p == 5'd16;
         2'd1:    return p == 5'd4;
         2'd2:    return p == 5'd21;
         default: return 1'b0;
      endcase
   endfunction

   state_t          state, next_state;
   logic [1:0]      wiring [NUM_ROTORS];
   logic [4:0]      ring   [NUM_ROTORS];
   logic [4:0]      pos    [NUM_ROTORS];
   logic [IW-1:0]   rot;
   logic [4:0]      cur;
   logic [NUM_ROTORS-1:0] step;
   logic [NUM_ROTORS-1:0] notch;
   logic [1:0]      sel_w;
   logic [4:0]      sel_s;
   logic [4:0]      fwd_res;
   logic [4:0]      bwd_res;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (in_valid && in_ready) next_state = (in_letter < 5'd26) ? STEP : DONE;
         STEP: next_state = FWD;
         FWD:  if (rot == LAST) next_state = REFL;
         REFL: next_state = BWD;
         BWD:  if (rot == '0) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) && !cfg_we;
      out_valid = (state == DONE);
   end

   // Stepping decisions use the pre-step positions of every rotor at once.
   always_comb begin
      notch = '0;
      step  = '0;
      for (int unsigned k = 0; k < NUM_ROTORS; k++) notch[k] = at_notch(wiring[k], pos[k]);
      step[0] = 1'b1;
      for (int unsigned k = 1; k < NUM_ROTORS; k++)
         step[k] = notch[k-1] | ((k < NUM_ROTORS - 1) & notch[k]);
   end

   always_comb begin
      sel_w   = wiring[rot];
      sel_s   = sub26(pos[rot], ring[rot]);
      fwd_res = sub26(wire_fwd(sel_w, add26(cur, sel_s)), sel_s);
      bwd_res = sub26(wire_inv(sel_w, add26(cur, sel_s)), sel_s);
   end

   always_comb begin
      positions = '0;
      for (int unsigned k = 0; k < NUM_ROTORS; k++) positions[5*k +: 5] = pos[k];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < NUM_ROTORS; k++) begin
            wiring[k] <= 2'd3;
            ring[k]   <= '0;
            pos[k]    <= '0;
         end
         rot        <= '0;
         cur        <= '0;
         out_letter <= '0;
      end else begin
         case (state)
            IDLE: begin
               rot <= '0;
               if (cfg_we && int'(cfg_idx) < NUM_ROTORS) begin
                  wiring[cfg_idx] <= cfg_wiring;
                  ring[cfg_idx]   <= cfg_ring;
                  pos[cfg_idx]    <= cfg_pos;
               end
               if (in_valid && in_ready) begin
                  cur <= in_letter;
                  if (in_letter >= 5'd26) out_letter <= in_letter;
               end
            end
            STEP: begin
               for (int unsigned k = 0; k < NUM_ROTORS; k++)
                  if (step[k]) pos[k] <= (pos[k] == 5'd25) ? '0 : pos[k] + 5'd1;
               rot <= '0;
            end
            FWD: begin
               cur <= fwd_res;
               if (rot != LAST) rot <= rot + 1'b1;
            end
            REFL: cur <= REFL_B[cur];
            BWD: begin
               cur <= bwd_res;
               if (rot == '0) out_letter <= bwd_res;
               else           rot <= rot - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rotor_stack.sv
// Self-checking bench for rotor_stack: cycle-level behavioural model compared
// every cycle, plus literal known-answer vectors.
module tb_rotor_stack;
   localparam int N   = 3;
   localparam int IW  = 2;
   localparam int LAT = 2 * N + 3;

   logic            clock = 1'b0;
   logic            reset;
   logic            cfg_we;
   logic [IW-1:0]   cfg_idx;
   logic [1:0]      cfg_wiring;
   logic [4:0]      cfg_ring;
   logic [4:0]      cfg_pos;
   logic            in_valid;
   logic [4:0]      in_letter;
   logic            in_ready;
   logic            out_valid;
   logic [4:0]      out_letter;
   logic [5*N-1:0]  positions;

   always #5 clock = ~clock;

   rotor_stack #(.NUM_ROTORS(N), .IW(IW)) dut (
      .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_wiring(cfg_wiring), .cfg_ring(cfg_ring), .cfg_pos(cfg_pos),
      .in_valid(in_valid), .in_letter(in_letter), .in_ready(in_ready),
      .out_valid(out_valid), .out_letter(out_letter), .positions(positions));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at %0t", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   string WSTR [3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                       "BDFHJLCPRTXVZNYEIWGAKMUSQO"};
   string RSTR = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   string NSTR = "QEV";

   int m_w [N];
   int m_ring [N];
   int m_pos [N];
   int phase = 0, lat = 0, pend = 0, m_res = 0, m_out = 0;

   function automatic int mod26(input int v);
      return ((v % 26) + 26) % 26;
   endfunction

   function automatic int wmap(input int w, input int i);
      string s;
      if (w == 3) return i;
      s = WSTR[w];
      return int'(s.getc(i)) - 65;
   endfunction

   function automatic int winv(input int w, input int y);
      for (int i = 0; i < 26; i++) if (wmap(w, i) == y) return i;
      return -1;
   endfunction

   function automatic int encipher(input int letter);
      int x, s;
      x = letter;
      for (int k = 0; k < N; k++) begin
         s = mod26(m_pos[k] - m_ring[k]);
         x = mod26(wmap(m_w[k], mod26(x + s)) - s);
      end
      x = int'(RSTR.getc(x)) - 65;
      for (int k = N - 1; k >= 0; k--) begin
         s = mod26(m_pos[k] - m_ring[k]);
         x = mod26(winv(m_w[k], mod26(x + s)) - s);
      end
      return x;
   endfunction

   function automatic bit turnover(input int k);
      if (m_w[k] == 3) return 1'b0;
      return m_pos[k] == int'(NSTR.getc(m_w[k])) - 65;
   endfunction

   task automatic model_step();
      bit adv [N];
      for (int k = 0; k < N; k++)
         adv[k] = (k == 0) || turnover(k - 1) || (k < N - 1 && turnover(k));
      for (int k = 0; k < N; k++) if (adv[k]) m_pos[k] = (m_pos[k] + 1) % 26;
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            m_w[k] = 3; m_ring[k] = 0; m_pos[k] = 0;
         end
         phase = 0; lat = 0; m_out = 0;
      end else if (phase == 0) begin
         if (cfg_we) begin
            if (int'(cfg_idx) < N) begin
               m_w[cfg_idx] = int'(cfg_wiring);
               m_ring[cfg_idx] = int'(cfg_ring);
               m_pos[cfg_idx] = int'(cfg_pos);
            end
         end else if (in_valid) begin
            phase = 1;
            pend = int'(in_letter);
            if (in_letter < 26) lat = LAT;
            else begin
               lat = 1;
               m_out = pend;
            end
         end
      end else begin
         if (phase == 1 && lat > 1) begin
            model_step();
            m_res = encipher(pend);
         end
         if (phase == lat) phase = 0;
         else begin
            phase++;
            if (phase == lat) m_out = m_res;
         end
      end
   end

   function automatic int exp_positions();
      logic [5*N-1:0] p;
      p = '0;
      for (int k = 0; k < N; k++) p[5*k +: 5] = 5'(m_pos[k]);
      return int'(p);
   endfunction

   always @(negedge clock) begin
      check("in_ready", int'(in_ready), int'(phase == 0 && !cfg_we));
      check("out_valid", int'(out_valid), int'(phase != 0 && phase == lat));
      check("out_letter", int'(out_letter), m_out);
      check("positions", int'(positions), exp_positions());
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_cfg(input int idx, input int w, input int r, input int p);
      cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_wiring = 2'(w); cfg_ring = 5'(r); cfg_pos = 5'(p);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic wait_accept(input int l);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; in_letter = 5'(l);
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("accept");
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send(input int l, output int r, output int cyc);
      wait_accept(l);
      r = -1; cyc = -1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         if (out_valid) begin r = int'(out_letter); cyc = i; break; end
      end
      if (cyc < 0) timeout("result");
      tick();
   endtask

   task automatic no_pulse(input string name, input int n);
      int seen;
      seen = 0;
      repeat (n) begin
         @(negedge clock);
         if (out_valid) seen = 1;
      end
      check(name, seen, 0);
      tick();
   endtask

   int r, cyc, saved;
   int pt [5];
   int ct [5];
   int known [5] = '{1, 3, 25, 6, 14};

   initial begin
      cfg_we = 1'b0; cfg_idx = '0; cfg_wiring = '0; cfg_ring = '0; cfg_pos = '0;
      in_valid = 1'b0; in_letter = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      check("rst_positions", int'(positions), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_letter", int'(out_letter), 0);

      send(0, r, cyc);
      check("default_A", r, 24);
      check("latency", cyc, LAT);
      send(24, r, cyc);
      check("default_Y", r, 0);

      do_cfg(2, 0, 0, 0); do_cfg(1, 1, 0, 0); do_cfg(0, 2, 0, 0);
      for (int i = 0; i < 5; i++) begin
         send(0, r, cyc);
         check("known_vector", r, known[i]);
      end
      check("known_positions", int'(positions), 5);

      do_cfg(2, 0, 0, 0); do_cfg(1, 1, 0, 3); do_cfg(0, 2, 0, 20);
      send(0, r, cyc);
      check("dstep_1", int'(positions), int'({5'd0, 5'd3, 5'd21}));
      send(0, r, cyc);
      check("dstep_2", int'(positions), int'({5'd0, 5'd4, 5'd22}));
      send(0, r, cyc);
      check("dstep_3", int'(positions), int'({5'd1, 5'd5, 5'd23}));

      do_cfg(2, 0, 1, 0); do_cfg(1, 1, 1, 0); do_cfg(0, 2, 1, 0);
      for (int i = 0; i < 5; i++) begin
         pt[i] = $urandom_range(0, 25);
         send(pt[i], ct[i], cyc);
      end
      do_cfg(2, 0, 1, 0); do_cfg(1, 1, 1, 0); do_cfg(0, 2, 1, 0);
      for (int i = 0; i < 5; i++) begin
         send(ct[i], r, cyc);
         check("reciprocity", r, pt[i]);
      end

      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_wiring = 2'd2; cfg_ring = 5'd0; cfg_pos = 5'd7;
      in_valid = 1'b1; in_letter = 5'd0;
      tick();
      cfg_we = 1'b0; in_valid = 1'b0;
      check("cfg_over_letter_pos", int'(positions[4:0]), 7);
      no_pulse("cfg_over_letter_pulse", 12);

      wait_accept(2);
      tick();
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pos = 5'd20;
      tick();
      cfg_we = 1'b0;
      cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (out_valid) begin cyc = i; break; end
      end
      if (cyc < 0) timeout("busy_cfg_result");
      tick();
      check("busy_cfg_dropped", int'(positions[4:0]), 8);

      saved = int'(positions);
      wait_accept(27);
      @(negedge clock);
      check("oor_valid", int'(out_valid), 1);
      check("oor_letter", int'(out_letter), 27);
      check("oor_positions", int'(positions), saved);
      tick();
      check("oor_ready", int'(in_ready), 1);

      wait_accept(0);
      repeat (N + 2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clock);
      check("abort_ready", int'(in_ready), 1);
      check("abort_positions", int'(positions), 0);
      tick();
      no_pulse("abort_pulse", 12);

      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_letter = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(26, 31))
                                                 : 5'($urandom_range(0, 25));
         cfg_we     = ($urandom_range(0, 9) == 0);
         cfg_idx    = IW'($urandom_range(0, 3));
         cfg_wiring = 2'($urandom_range(0, 3));
         cfg_ring   = 5'($urandom_range(0, 25));
         cfg_pos    = 5'($urandom_range(0, 25));
         tick();
      end
      in_valid = 1'b0; cfg_we = 1'b0;
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rotor_stack.md
# rotor_stack

Parametrised, clocked Enigma rotor stack that replaces per-rotor combinational chaining with a single sequential datapath. It holds NUM_ROTORS configurable rotors plus a fixed reflector and accepts one index-encoded letter per transaction. For each letter it performs the stepping rule, including the double-step, then passes the letter through the rotors forward, through the reflector, and back through the rotors. It sits between the keyboard/letter encoder and the lampboard/display logic.

## Interface
- NUM_ROTORS, 3: number of rotors, ≥2. Index 0 is the rightmost (fast) rotor.
- IW, $clog2(NUM_ROTORS) (min 1): width of cfg_idx.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  IW  rotor index to write.
- cfg_wiring  in  2  wiring select: 0 = I, 1 = II, 2 = III, 3 = identity.
- cfg_ring  in  5  ring setting, 0–25.
- cfg_pos  in  5  start position, 0–25.
- in_valid  in  1  letter request.
- in_letter  in  5  letter, A=0 … Z=25.
- in_ready  out  1  block can accept a letter.
- out_valid  out  1  one-cycle result pulse.
- out_letter  out  5  enciphered letter, held until the next result.
- positions  out  5*NUM_ROTORS  current rotor positions; rotor k occupies bits [5k+4:5k].

## Operation
- Wirings, A→Z:
  - I: EKMFLGDQVZNTOWYHXUSPAIBRCJ, turnover at Q.
  - II: AJDKSIRUXBLHWTMCQGZNPYFVOE, turnover at E.
  - III: BDFHJLCPRTXVZNYEIWGAKMUSQO, turnover at V.
  - Identity: no turnover.
  - Reflector, fixed UKW-B: YRUHQSLDPXNGOKMIEBFZCWVJAT.
  - Backward pass uses the inverse permutation of each rotor.
- Per-rotor arithmetic (all mod 26):
  - Offset s = pos − ring.
  - Forward: y = W[(x+s)] − s.
  - Backward: y = W⁻¹[(x+s)] − s.
  - Sums are formed in 6 bits and reduced by a single conditional ±26.
- Stepping, evaluated on pre-step positions, all rotors updated in the same cycle:
  - Rotor 0 always steps.
  - Rotor k>0 steps if rotor k−1 is at its turnover letter.
  - Rotor k, for 0<k<NUM_ROTORS−1, also steps if rotor k itself is at its turnover letter (double-step).
  - A stepping rotor moves 25→0.
- FSM:
  - IDLE: in_ready = ~cfg_we.
    - cfg_we with cfg_idx < NUM_ROTORS writes that rotor's wiring, ring and pos; cfg_idx ≥ NUM_ROTORS is ignored.
    - On in_valid & in_ready with in_letter < 26, latch the letter and go to STEP.
    - in_letter ≥ 26 is accepted, goes straight to DONE with out_letter = in_letter, and no rotor steps.
  - STEP: update positions → FWD.
  - FWD: one rotor per cycle, index 0 up to NUM_ROTORS−1 → REFL.
  - REFL: one cycle → BWD.
  - BWD: one rotor per cycle, index NUM_ROTORS−1 down to 0 → DONE.
  - DONE: out_valid = 1 and out_letter is registered → IDLE.
- cfg_we outside IDLE is dropped.
- in_valid while in_ready = 0 is not accepted.
- Configuration written in IDLE takes effect on the next letter.

## Timing
- Reset values:
  - State IDLE; in_ready = 1 when cfg_we = 0.
  - out_valid = 0, out_letter = 0.
  - All rotors: wiring 3, ring 0, pos 0, so positions = 0.
- Reset asserted mid-transaction aborts it: no out_valid pulse, and the configuration returns to defaults.
- Accept in cycle T:
  - Positions change at the edge ending T+1.
  - out_valid is high in cycle T+2·NUM_ROTORS+3; this is T+9 for NUM_ROTORS = 3.
  - in_ready is high again from T+2·NUM_ROTORS+4.
  - Back-to-back throughput is one letter per 2·NUM_ROTORS+4 cycles.
- Out-of-range letter accepted at T: out_valid at T+1, in_ready at T+2.
- positions is registered and always reflects the committed state.

## Test plan
- Reset defaults: after reset, send A → out_letter Y at T+9, positions 0; send Y → A.
- Known vector: rotors 2/1/0 = I/II/III, rings 0, positions 0; send A×5 → B,D,Z,G,O; final positions: rotor 0 = 5, rotor 1 = 0, rotor 2 = 0.
- Double-step: same wirings, positions (rotor 2,1,0) = A,D,U; three letters → positions A,D,V, then A,E,W, then B,F,X.
- Reciprocity and ring setting: rings B,B,B, positions A,A,A; encipher the 5-letter output of a fresh run from the same setup → the original plaintext is recovered.
- Handshake: cfg_we in the same cycle as in_valid in IDLE → config written, letter not accepted. cfg_we during FWD → ignored. in_letter = 27 → out_letter 27 at T+1, positions unchanged.
- Reset mid-operation: assert reset during BWD → no out_valid, positions 0, in_ready = 1 the cycle after reset deasserts.
